// File: rtl/nn_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// nn_ctrl_pkg
// Shared definitions for the network run sequencer: the controller state
// encoding, the default interface widths and a small width helper.
// No ports (package).
// ---------------------------------------------------------------------------
package nn_ctrl_pkg;

  // Default widths used by nn_run_sequencer parameters.
  localparam int IDX_W_DEFAULT   = 10;
  localparam int LABEL_W_DEFAULT = 8;
  localparam int CLASS_W_DEFAULT = 4;

  // Run controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } nn_state_e;

  // Width that can hold both the class result and the label once
  // zero-extended, so the two can be compared without truncation.
  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : nn_ctrl_pkg

// File: rtl/nn_watchdog.sv
// ---------------------------------------------------------------------------
// nn_watchdog
// Counts consecutive cycles the sequencer spends waiting for the datapath
// and flags expiry on the TIMEOUT_CYC-th such cycle. Only instantiated by
// nn_run_sequencer when the TIMEOUT_EN macro is defined.
//
// Ports
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   clear   in   restart the count (sequencer is not waiting)
//   enable  in   count this cycle (sequencer is waiting)
//   expire  out  high during the TIMEOUT_CYC-th enabled cycle
// ---------------------------------------------------------------------------
module nn_watchdog
  import nn_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturate at the last count; the sequencer leaves WAIT on expiry, which
  // clears the counter on the following cycle anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == LAST_CNT);

endmodule : nn_watchdog

// File: rtl/nn_run_sequencer.sv
// ---------------------------------------------------------------------------
// nn_run_sequencer
// Steps a neural-network datapath through NUM_SAMPLES test samples, fetches
// the matching label from a synchronous label memory and keeps running
// totals of completed and correctly classified samples.
//
// Optional feature: define TIMEOUT_EN to add a WAIT-state watchdog
// (nn_watchdog). Without it the sequencer waits for nn_done indefinitely and
// timeout_err is tied low.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   begin a run (looked at only in IDLE)
//   busy         out  high while a run is in progress (LOAD/WAIT/DONE)
//   run_done     out  one-cycle pulse in the DONE cycle
//   nn_start     out  one-cycle pulse to the datapath (LOAD cycle)
//   nn_idx       out  current sample index
//   nn_done      in   datapath completion pulse
//   nn_result    in   predicted class, valid with nn_done
//   lbl_addr     out  label memory address (same as nn_idx)
//   lbl_data     in   label, valid one cycle after lbl_addr
//   total_cnt    out  samples completed in this run
//   correct_cnt  out  samples whose result matched the label
//   timeout_err  out  sticky watchdog flag (TIMEOUT_EN only, else 0)
// ---------------------------------------------------------------------------
module nn_run_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_SAMPLES = 750,
  parameter int IDX_W       = IDX_W_DEFAULT,
  parameter int LABEL_W     = LABEL_W_DEFAULT,
  parameter int CLASS_W     = CLASS_W_DEFAULT,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               run_done,
  output logic               nn_start,
  output logic [IDX_W-1:0]   nn_idx,
  input  logic               nn_done,
  input  logic [CLASS_W-1:0] nn_result,
  output logic [IDX_W-1:0]   lbl_addr,
  input  logic [LABEL_W-1:0] lbl_data,
  output logic [IDX_W-1:0]   total_cnt,
  output logic [IDX_W-1:0]   correct_cnt,
  output logic               timeout_err
);

  localparam int CMP_W = max_w(CLASS_W, LABEL_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

  nn_state_e        state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] total_q;
  logic [IDX_W-1:0] correct_q;
  logic             busy_q;
  logic             run_done_q;
  logic             nn_start_q;

  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] total_d;
  logic [IDX_W-1:0] correct_d;

  logic [CMP_W-1:0] result_ext;
  logic [CMP_W-1:0] label_ext;
  logic             match;
  logic             wd_expire;
  logic             sample_end;

  // The label was addressed in LOAD, so lbl_data is already valid for the
  // whole WAIT state; compare both operands at a common width.
  assign result_ext = CMP_W'(nn_result);
  assign label_ext  = CMP_W'(lbl_data);
  assign match      = (result_ext == label_ext);

`ifdef TIMEOUT_EN
  logic wd_clear;
  logic wd_enable;
  logic timeout_q;

  assign wd_enable = (state_q == ST_WAIT);
  assign wd_clear  = (state_q != ST_WAIT);

  nn_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  assign timeout_err = timeout_q;
`else
  // No watchdog: the comparison is constant-false for any legal TIMEOUT_CYC,
  // so WAIT only ever ends on nn_done.
  assign wd_expire   = (TIMEOUT_CYC < 0);
  assign timeout_err = 1'b0;
`endif

  // A sample ends on nn_done, or on watchdog expiry (counted as incorrect).
  assign sample_end = (state_q == ST_WAIT) && (nn_done || wd_expire);

  always_comb begin
    idx_d     = idx_q + 1'b1;
    total_d   = total_q + 1'b1;
    correct_d = (nn_done && match) ? (correct_q + 1'b1) : correct_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      total_q    <= '0;
      correct_q  <= '0;
      busy_q     <= 1'b0;
      run_done_q <= 1'b0;
      nn_start_q <= 1'b0;
`ifdef TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; each is raised only for the cycle it
      // belongs to by the transition that enters that cycle.
      run_done_q <= 1'b0;
      nn_start_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_LOAD;
            idx_q      <= '0;
            total_q    <= '0;
            correct_q  <= '0;
            busy_q     <= 1'b1;
            nn_start_q <= 1'b1;
`ifdef TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
          end
        end

        ST_LOAD: begin
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          if (sample_end) begin
            total_q   <= total_d;
            correct_q <= correct_d;
`ifdef TIMEOUT_EN
            if (!nn_done) begin
              timeout_q <= 1'b1;
            end
`endif
            if (idx_q == LAST_IDX) begin
              state_q    <= ST_DONE;
              run_done_q <= 1'b1;
            end else begin
              idx_q      <= idx_d;
              state_q    <= ST_LOAD;
              nn_start_q <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign run_done    = run_done_q;
  assign nn_start    = nn_start_q;
  assign nn_idx      = idx_q;
  assign lbl_addr    = idx_q;
  assign total_cnt   = total_q;
  assign correct_cnt = correct_q;

endmodule : nn_run_sequencer

// File: tb/tb_nn_run_sequencer.sv
// ---------------------------------------------------------------------------
// tb_nn_run_sequencer
// Directed and randomized checks of nn_run_sequencer. u_dut runs 4-sample
// runs against a behavioural datapath/label-memory model; u_one is a
// single-sample instance. Expected counts and run latency come from the
// sample list: one LOAD cycle plus the datapath latency per sample, plus
// the DONE cycle.
// ---------------------------------------------------------------------------
module tb_nn_run_sequencer;

  localparam int IDX_W   = 10;
  localparam int LABEL_W = 8;
  localparam int CLASS_W = 4;
  localparam int N       = 4;

  logic clk;
  logic rst;

  // u_dut signals
  logic               start;
  logic               busy, run_done, nn_start, timeout_err;
  logic [IDX_W-1:0]   nn_idx, lbl_addr, total_cnt, correct_cnt;
  logic               nn_done;
  logic [CLASS_W-1:0] nn_result;
  logic [LABEL_W-1:0] lbl_data;

  // u_one signals
  logic               start1;
  logic               busy1, run_done1, nn_start1, timeout_err1;
  logic [IDX_W-1:0]   nn_idx1, lbl_addr1, total_cnt1, correct_cnt1;
  logic               nn_done1;
  logic [CLASS_W-1:0] nn_result1;
  logic [LABEL_W-1:0] lbl_data1;

  // Datapath model state
  logic [LABEL_W-1:0] lbl_mem [N];
  logic [CLASS_W-1:0] res_mem [N];
  int                 lat_mem [N];
  int                 hang_idx;
  bit                 spur;
  logic               dp_done, man_done;
  logic [CLASS_W-1:0] dp_res, man_res;

  int n_cmp  = 0;
  int n_fail = 0;
  int rd_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign nn_done   = dp_done | man_done;
  assign nn_result = man_done ? man_res : dp_res;

  nn_run_sequencer #(
    .NUM_SAMPLES (N), .IDX_W (IDX_W), .LABEL_W (LABEL_W),
    .CLASS_W (CLASS_W), .TIMEOUT_CYC (8)
  ) u_dut (
    .clk (clk), .rst (rst), .start (start), .busy (busy),
    .run_done (run_done), .nn_start (nn_start), .nn_idx (nn_idx),
    .nn_done (nn_done), .nn_result (nn_result), .lbl_addr (lbl_addr),
    .lbl_data (lbl_data), .total_cnt (total_cnt),
    .correct_cnt (correct_cnt), .timeout_err (timeout_err)
  );

  nn_run_sequencer #(
    .NUM_SAMPLES (1), .IDX_W (IDX_W), .LABEL_W (LABEL_W),
    .CLASS_W (CLASS_W), .TIMEOUT_CYC (8)
  ) u_one (
    .clk (clk), .rst (rst), .start (start1), .busy (busy1),
    .run_done (run_done1), .nn_start (nn_start1), .nn_idx (nn_idx1),
    .nn_done (nn_done1), .nn_result (nn_result1), .lbl_addr (lbl_addr1),
    .lbl_data (lbl_data1), .total_cnt (total_cnt1),
    .correct_cnt (correct_cnt1), .timeout_err (timeout_err1)
  );

  // Synchronous-read label memories.
  always @(posedge clk) lbl_data  <= (lbl_addr < IDX_W'(N)) ? lbl_mem[lbl_addr[1:0]] : '0;
  always @(posedge clk) lbl_data1 <= (lbl_addr1 == '0) ? 8'd5 : 8'd0;

  always @(negedge clk) if (run_done === 1'b1) rd_cnt++;

  // Datapath model: after each nn_start, answer with res_mem[idx] lat_mem[idx]
  // cycles later; never answer for sample hang_idx. With spur set, also pulse
  // nn_done (with the correct label) during the LOAD cycle itself.
  int di;
  initial begin
    dp_done = 1'b0;
    dp_res  = '0;
    forever begin
      @(negedge clk);
      if (nn_start === 1'b1) begin
        di = int'(nn_idx[1:0]);
        if (spur) begin
          dp_res  = lbl_mem[di][CLASS_W-1:0];
          dp_done = 1'b1;
        end
        @(posedge clk); #1 dp_done = 1'b0;
        if (di != hang_idx) begin
          repeat (lat_mem[di] - 1) begin @(posedge clk); #1; end
          dp_res  = res_mem[di];
          dp_done = 1'b1;
          @(posedge clk); #1 dp_done = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Launch a run and return the cycle (start cycle = 0) in which run_done is
  // seen, or -1 if it does not appear within budget. start is pulsed again in
  // cycle poke_c (must be ignored as the sequencer is busy then).
  task automatic run_measure(input int poke_c, input int budget, output int cyc);
    start = 1'b1;
    tick();
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      start = (c == poke_c);
      @(negedge clk);
      if (c == 1) begin
        check("load_idx", nn_idx, 0);
        check("load_nn_start", nn_start, 1);
      end
      if (run_done === 1'b1) begin
        cyc = c;
        break;
      end
      tick();
    end
    start = 1'b0;
    tick();
  endtask

  task automatic set_samples(input int l0, l1, l2, l3, r0, r1, r2, r3);
    lbl_mem[0] = LABEL_W'(l0); lbl_mem[1] = LABEL_W'(l1);
    lbl_mem[2] = LABEL_W'(l2); lbl_mem[3] = LABEL_W'(l3);
    res_mem[0] = CLASS_W'(r0); res_mem[1] = CLASS_W'(r1);
    res_mem[2] = CLASS_W'(r2); res_mem[3] = CLASS_W'(r3);
    for (int i = 0; i < N; i++) lat_mem[i] = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  int cyc, rd0, exp_cyc, exp_total, exp_correct, poke;
  logic [LABEL_W-1:0] lab;

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    man_done = 1'b0; man_res = '0; nn_done1 = 1'b0; nn_result1 = '0;
    hang_idx = -1; spur = 1'b0;
    set_samples(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_run_done", run_done, 0);
    check("rst_nn_start", nn_start, 0);
    check("rst_nn_idx", nn_idx, 0);
    check("rst_total", total_cnt, 0);
    check("rst_correct", correct_cnt, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_busy1", busy1, 0);
    tick();

    // Directed 4-sample run, one-cycle datapath
    set_samples(3, 1, 7, 0, 3, 2, 7, 0);
    rd0 = rd_cnt;
    run_measure(-1, 60, cyc);
    check("dir_latency", cyc, 9);
    check("dir_total", total_cnt, 4);
    check("dir_correct", correct_cnt, 3);
    check("dir_timeout", timeout_err, 0);
    repeat (3) tick();
    check("hold_busy", busy, 0);
    check("hold_total", total_cnt, 4);
    check("hold_correct", correct_cnt, 3);
    check("dir_run_done_pulses", rd_cnt - rd0, 1);

    // nn_done in IDLE is ignored
    man_res = 4'd3; man_done = 1'b1; tick(); man_done = 1'b0; tick();
    check("idle_done_total", total_cnt, 4);
    check("idle_done_correct", correct_cnt, 3);

    // nn_done also pulsed in every LOAD cycle is ignored there
    set_samples(3, 1, 7, 0, 3, 1, 7, 0);
    spur = 1'b1;
    run_measure(-1, 60, cyc);
    spur = 1'b0;
    check("load_done_latency", cyc, 9);
    check("load_done_total", total_cnt, 4);
    check("load_done_correct", correct_cnt, 4);

    // start pulsed during WAIT of sample 1 is ignored
    set_samples(3, 1, 7, 0, 3, 2, 7, 0);
    lat_mem[1] = 3;
    rd0 = rd_cnt;
    run_measure(5, 60, cyc);
    repeat (5) tick();
    check("mid_start_latency", cyc, 11);
    check("mid_start_total", total_cnt, 4);
    check("mid_start_correct", correct_cnt, 3);
    check("mid_start_busy", busy, 0);
    check("mid_start_pulses", rd_cnt - rd0, 1);

    // rst during WAIT of sample 2, then a clean restart
    set_samples(3, 1, 7, 0, 3, 2, 7, 0);
    hang_idx = 2;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    check("pre_rst_idx", nn_idx, 2);
    check("pre_rst_busy", busy, 1);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_idx", nn_idx, 0);
    check("post_rst_total", total_cnt, 0);
    check("post_rst_correct", correct_cnt, 0);
    check("post_rst_nn_start", nn_start, 0);
    tick();
    hang_idx = -1;
    run_measure(-1, 60, cyc);
    check("restart_latency", cyc, 9);
    check("restart_total", total_cnt, 4);
    check("restart_correct", correct_cnt, 3);

    // Sample 1 never completes
    set_samples(3, 1, 7, 0, 3, 1, 7, 0);
    hang_idx = 1;
`ifdef TIMEOUT_EN
    run_measure(-1, 60, cyc);
    check("wd_latency", cyc, 16);
    check("wd_total", total_cnt, 4);
    check("wd_correct", correct_cnt, 3);
    check("wd_flag", timeout_err, 1);
    hang_idx = -1;
    run_measure(-1, 60, cyc);
    check("wd_cleared", timeout_err, 0);
    check("wd_next_correct", correct_cnt, 4);
`else
    run_measure(-1, 40, cyc);
    check("hang_no_done", cyc, -1);
    @(negedge clk);
    check("hang_busy", busy, 1);
    check("hang_idx", nn_idx, 1);
    check("hang_total", total_cnt, 1);
    check("hang_timeout", timeout_err, 0);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    hang_idx = -1;
`endif

    // Randomized runs against the arithmetic model
    for (int k = 0; k < 8; k++) begin
      exp_cyc = 1;
      exp_correct = 0;
      exp_total = N;
      for (int i = 0; i < N; i++) begin
        lab = LABEL_W'($urandom_range(0, 20));
        lbl_mem[i] = lab;
        res_mem[i] = ($urandom_range(0, 1) == 1) ? lab[CLASS_W-1:0]
                                                 : CLASS_W'($urandom_range(0, 15));
        lat_mem[i] = $urandom_range(1, 4);
        exp_cyc += 1 + lat_mem[i];
        if (int'(lbl_mem[i]) == int'(res_mem[i])) exp_correct++;
      end
      spur = bit'($urandom_range(0, 1));
      poke = $urandom_range(2, exp_cyc - 1);
      run_measure(poke, 80, cyc);
      spur = 1'b0;
      check("rand_latency", cyc, exp_cyc);
      check("rand_total", total_cnt, exp_total);
      check("rand_correct", correct_cnt, exp_correct);
    end

    // Single-sample instance: label 5, result 5
    start1 = 1'b1; tick(); start1 = 1'b0;
    @(negedge clk);
    check("one_nn_start", nn_start1, 1);
    check("one_busy", busy1, 1);
    check("one_idx", nn_idx1, 0);
    tick();
    nn_done1 = 1'b1; nn_result1 = 4'd5;
    @(negedge clk);
    check("one_no_early_done", run_done1, 0);
    tick();
    nn_done1 = 1'b0;
    @(negedge clk);
    check("one_run_done", run_done1, 1);
    check("one_total", total_cnt1, 1);
    check("one_correct", correct_cnt1, 1);
    check("one_timeout", timeout_err1, 0);
    tick();
    @(negedge clk);
    check("one_idle", busy1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_nn_run_sequencer

// File: doc/nn_run_sequencer.md
NN_RUN_SEQUENCER -- requirements
Module: nn_run_sequencer

Interface
REQ-001 SHALL have parameter NUM_SAMPLES, default 750, meaning test samples per run (1..2^IDX_W-1).
REQ-002 SHALL have parameter IDX_W, default 10, meaning width of sample index and counters.
REQ-003 SHALL have parameter LABEL_W, default 8, meaning label memory data width.
REQ-004 SHALL have parameter CLASS_W, default 4, meaning network result width.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 4096, meaning maximum WAIT cycles (used only with TIMEOUT_EN).
REQ-006 SHALL use one clock and a synchronous, active-high reset, with ports named as follows.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port start, input, 1 bit: begin run; sampled only in IDLE.
REQ-010 SHALL have port busy, output, 1 bit: high in LOAD, WAIT and DONE.
REQ-011 SHALL have port run_done, output, 1 bit: one-cycle pulse at end of run.
REQ-012 SHALL have port nn_start, output, 1 bit: one-cycle pulse to the network datapath.
REQ-013 SHALL have port nn_idx, output, IDX_W bits: current sample index.
REQ-014 SHALL have port nn_done, input, 1 bit: datapath completion pulse (batch_done).
REQ-015 SHALL have port nn_result, input, CLASS_W bits: predicted class, valid with nn_done.
REQ-016 SHALL have port lbl_addr, output, IDX_W bits: label memory address, equal to nn_idx.
REQ-017 SHALL have port lbl_data, input, LABEL_W bits: label, synchronous read, valid 1 cycle after lbl_addr.
REQ-018 SHALL have port total_cnt, output, IDX_W bits: samples completed.
REQ-019 SHALL have port correct_cnt, output, IDX_W bits: samples whose result matched the label.
REQ-020 SHALL have port timeout_err, output, 1 bit: sticky watchdog flag.

Function
REQ-021 SHALL implement FSM states IDLE, LOAD, WAIT, DONE.
REQ-022 SHALL, on start=1 in IDLE, go to LOAD next cycle, clearing idx, total_cnt, correct_cnt and timeout_err.
REQ-023 SHALL assert nn_start for exactly the LOAD cycle, then enter WAIT.
REQ-024 SHALL ignore nn_done outside WAIT; a WAIT-state nn_done ends WAIT.
REQ-025 SHALL, on nn_done in WAIT, increment total_cnt and, if {0,nn_result}==lbl_data (both zero-extended to max(CLASS_W,LABEL_W)), increment correct_cnt, in the same edge.
REQ-026 SHALL go from WAIT to DONE when idx==NUM_SAMPLES-1; otherwise increment idx and go to LOAD.
REQ-027 SHALL give run_done=1 for the single DONE cycle, then return to IDLE.
REQ-028 SHALL ignore start when not in IDLE; start held high re-triggers a run from IDLE.
REQ-029 SHALL hold counters stable after DONE until the next start or rst.
REQ-030 SHALL give minimum per-sample cost of 2 cycles (LOAD + 1 WAIT); run latency start->run_done = 2*NUM_SAMPLES+1 cycles with 1-cycle datapath.

Reset
REQ-031 SHALL, on rst=1 at any state including mid-run, go to IDLE next edge with all outputs and counters 0.
REQ-032 SHALL give rst priority over start and nn_done in the same cycle.

Configuration
REQ-033 SHALL, with TIMEOUT_EN defined, count WAIT cycles; at TIMEOUT_CYC without nn_done, set timeout_err, increment total_cnt only (counted incorrect), and advance as REQ-026.
REQ-034 SHALL, without TIMEOUT_EN, have WAIT wait indefinitely, timeout_err tied 0, and no watchdog logic.

Structure
REQ-035 SHALL place the state enum and default widths (IDX_W, LABEL_W, CLASS_W) in shared package nn_ctrl_pkg.
REQ-036 SHALL implement the watchdog as sub-module nn_watchdog (clear, enable, expire), instantiated only under TIMEOUT_EN.

Verification
REQ-037 SHALL verify: NUM_SAMPLES=4, labels {3,1,7,0}, results {3,2,7,0}, 1-cycle datapath -> total_cnt=4, correct_cnt=3, run_done at cycle 9 after start.
REQ-038 SHALL verify: start pulsed during WAIT of sample 1 -> ignored, counts unaffected, single run_done.
REQ-039 SHALL verify: rst asserted in WAIT of sample 2 -> next cycle IDLE, busy=0, counters 0; new start restarts at idx 0.
REQ-040 SHALL verify: nn_done pulsed in LOAD and IDLE -> no count change.
REQ-041 SHALL verify: TIMEOUT_EN, TIMEOUT_CYC=8, sample 1 never completes -> after 8 WAIT cycles timeout_err=1, total_cnt increments, correct_cnt unchanged, run continues to idx 2.
REQ-042 SHALL verify: NUM_SAMPLES=1, label 5, result 5 -> total_cnt=1, correct_cnt=1, run_done 3 cycles after start.
